// File: rtl/mux_8_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin packet arbiter.
package mux_8_rr_arbiter_pkg;

  localparam int NUM_REQ   = 8;
  localparam int SEL_WIDTH = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_WIDTH-1:0] sel);
    sel_to_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
  endfunction

endpackage

// File: rtl/mux_8_rr_arbiter_rr_priority_enc_8.sv
// Rotating priority encoder: first set request bit at or above ptr, wrapping modulo 8.
module rr_priority_enc_8
  import mux_8_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [SEL_WIDTH-1:0] idx
);

  logic [SEL_WIDTH-1:0] cand;

  // Scan from ptr upward; the 3-bit add wraps naturally past requester 7.
  always_comb begin
    found = 1'b0;
    idx   = {SEL_WIDTH{1'b0}};
    cand  = {SEL_WIDTH{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + SEL_WIDTH'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/mux_8_rr_arbiter.sv
// Round-robin packet arbiter driving the select of an external 8:1 TX datapath mux.
// Grants are held for a whole packet, optionally cut short after MAX_BURST beats.
module mux_8_rr_arbiter
  import mux_8_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_arst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ-1:0]   i_last,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [SEL_WIDTH-1:0] o_sel,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_valid,
  output logic                 o_last,
  input  logic                 i_ready,
  output logic                 o_busy
);

  localparam logic                 FORCE_EN = (MAX_BURST != 0);
  localparam logic [CNT_WIDTH-1:0] FORCE_AT = (MAX_BURST == 0) ? {CNT_WIDTH{1'b0}}
                                                               : CNT_WIDTH'(MAX_BURST - 1);

  state_t               state;
  logic [SEL_WIDTH-1:0] ptr;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 found;
  logic [SEL_WIDTH-1:0] win_idx;
  logic                 force_rel;
  logic                 beat;

  rr_priority_enc_8 u_prio (
    .req   (i_req),
    .ptr   (ptr),
    .found (found),
    .idx   (win_idx)
  );

  assign force_rel = FORCE_EN && (beat_cnt == FORCE_AT);
  assign o_busy    = (state == ST_GRANT);
  assign beat      = o_valid & i_ready;

  // Downstream handshake is a pure mux of the granted source's lines.
  always_comb begin
    o_valid = 1'b0;
    o_last  = 1'b0;
    o_ack   = {NUM_REQ{1'b0}};
    if (state == ST_GRANT) begin
      o_valid = i_req[o_sel];
      o_last  = i_last[o_sel] | force_rel;
      o_ack   = sel_to_onehot(o_sel) & {NUM_REQ{i_ready}};
    end else begin
      o_valid = 1'b0;
      o_last  = 1'b0;
      o_ack   = {NUM_REQ{1'b0}};
    end
  end

  // Arbitration FSM; o_sel deliberately keeps its value through IDLE.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state    <= ST_IDLE;
      o_sel    <= {SEL_WIDTH{1'b0}};
      o_grant  <= {NUM_REQ{1'b0}};
      ptr      <= {SEL_WIDTH{1'b0}};
      beat_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state    <= ST_GRANT;
            o_sel    <= win_idx;
            o_grant  <= sel_to_onehot(win_idx);
            beat_cnt <= {CNT_WIDTH{1'b0}};
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (beat && o_last) begin
            state    <= ST_IDLE;
            ptr      <= o_sel + SEL_WIDTH'(1);
            beat_cnt <= {CNT_WIDTH{1'b0}};
            o_grant  <= {NUM_REQ{1'b0}};
          end else if (beat) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
          end else begin
            beat_cnt <= beat_cnt;
          end
        end
        default: begin
          state    <= ST_IDLE;
          o_grant  <= {NUM_REQ{1'b0}};
          beat_cnt <= {CNT_WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule
